// File: rtl/cam_stream_packer_if.sv
// Stream channel used on both sides of the CAM packer.
// The slave modport is the receiving side and the master modport is the sending side.
// TLAST and TUSER are carried on both sides. Only the input stream gives them meaning.
interface cam_stream_packer_if #(
    parameter int DW = 32
) ();
    logic [DW-1:0] TDATA;
    logic          TVALID;
    logic          TREADY;
    logic          TLAST;
    logic          TUSER;

    modport master (output TDATA, output TVALID, output TLAST, output TUSER, input TREADY);
    modport slave  (input TDATA, input TVALID, input TLAST, input TUSER, output TREADY);
endinterface

// File: rtl/cam_stream_packer.sv
// CAM stream packer.
// It gathers up to 16 vertex IDs of an adjacency list into one wide beat for the CAM kernel.
// Beat layout: lanes hold the IDs in arrival order.
// The header above the lanes holds the lane count, the last flag, the list mode and the first flag.
// The output register is a single stage. New input is accepted whenever that stage is empty
// or is being drained in the same cycle.
module cam_stream_packer #(
    parameter int C_DATA_WIDTH = 520,
    parameter int C_ID_WIDTH   = 32
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst_n,
    cam_stream_packer_if.slave     s,
    cam_stream_packer_if.master    m,
    output logic [31:0]            list_count
);

    localparam int LANES     = 16;
    localparam int LANE_BITS = LANES * C_ID_WIDTH;

    logic [3:0]              lane_cnt_r;
    logic                    in_list_r;
    logic                    mode_r;
    logic                    beat_first_r;
    logic [C_ID_WIDTH-1:0]   lanes_r [LANES];
    logic [C_DATA_WIDTH-1:0] m_data_r;
    logic                    m_valid_r;
    logic [31:0]             list_count_r;

    logic                    s_ready_s;
    logic                    accept_s;
    logic                    complete_s;
    logic                    out_hs_s;
    logic                    word_mode_s;
    logic                    word_first_s;
    logic [C_DATA_WIDTH-1:0] beat_s;

    // Ready is forced low while reset is asserted, so nothing can be accepted during reset.
    assign s_ready_s  = ap_rst_n & (~m_valid_r | m.TREADY);
    assign accept_s   = s.TVALID & s_ready_s;
    assign complete_s = accept_s & ((lane_cnt_r == 4'd15) | s.TLAST);
    assign out_hs_s   = m_valid_r & m.TREADY;

    assign s.TREADY   = s_ready_s;
    assign m.TDATA    = m_data_r;
    assign m.TVALID   = m_valid_r;
    assign m.TLAST    = 1'b0;
    assign m.TUSER    = 1'b0;
    assign list_count = list_count_r;

    // Choose the mode and first flag for the word now on the input.
    // When this word opens a list, its own TUSER is used and the stored copy is ignored.
    always_comb begin
        word_mode_s  = mode_r;
        word_first_s = beat_first_r;
        if (in_list_r) begin
            word_mode_s = mode_r;
        end else begin
            word_mode_s = s.TUSER;
        end
        if (lane_cnt_r == 4'd0) begin
            word_first_s = ~in_list_r;
        end else begin
            word_first_s = beat_first_r;
        end
    end

    // Assemble the beat that would complete on this word.
    // Earlier lanes come from the buffer and the current word takes the next lane.
    // All lanes above it are zero.
    always_comb begin
        beat_s = '0;
        for (int k = 0; k < LANES; k++) begin
            if (4'(k) < lane_cnt_r) begin
                beat_s[k*C_ID_WIDTH +: C_ID_WIDTH] = lanes_r[k];
            end else if (4'(k) == lane_cnt_r) begin
                beat_s[k*C_ID_WIDTH +: C_ID_WIDTH] = s.TDATA;
            end else begin
                beat_s[k*C_ID_WIDTH +: C_ID_WIDTH] = '0;
            end
        end
        beat_s[LANE_BITS +: 5] = {1'b0, lane_cnt_r} + 5'd1;
        beat_s[LANE_BITS + 5]  = s.TLAST;
        beat_s[LANE_BITS + 6]  = word_mode_s;
        beat_s[LANE_BITS + 7]  = word_first_s;
    end

    // Packing state: lane buffer, lane counter, in-list flag, list mode and first-beat flag.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            for (int k = 0; k < LANES; k++) begin
                lanes_r[k] <= '0;
            end
            lane_cnt_r   <= 4'd0;
            in_list_r    <= 1'b0;
            mode_r       <= 1'b0;
            beat_first_r <= 1'b0;
        end else if (accept_s) begin
            lanes_r[lane_cnt_r] <= s.TDATA;
            lane_cnt_r          <= complete_s ? 4'd0 : lane_cnt_r + 4'd1;
            in_list_r           <= ~s.TLAST;
            if (!in_list_r) begin
                mode_r <= s.TUSER;
            end
            if (lane_cnt_r == 4'd0) begin
                beat_first_r <= ~in_list_r;
            end
        end
    end

    // Output register: it loads on beat completion and clears after a handshake.
    // A load is only possible when the stage is free, so a pending beat is never overwritten.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            m_valid_r <= 1'b0;
            m_data_r  <= '0;
        end else if (complete_s) begin
            m_valid_r <= 1'b1;
            m_data_r  <= beat_s;
        end else if (m.TREADY) begin
            m_valid_r <= 1'b0;
        end
    end

    // Count lists whose final beat has been handed over downstream.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            list_count_r <= 32'd0;
        end else if (out_hs_s && m_data_r[LANE_BITS + 5]) begin
            list_count_r <= list_count_r + 32'd1;
        end
    end

endmodule

// File: tb/tb_cam_stream_packer.sv
// Self-checking bench for cam_stream_packer.
// The stimulus side builds the expected beats of each list with plain arithmetic and queues them.
// A separate monitor pops and compares the queue on every output handshake.
module tb_cam_stream_packer;

    localparam int IDW = 32;
    localparam int DW  = 520;

    logic        ap_clk   = 1'b0;
    logic        ap_rst_n = 1'b1;
    logic [31:0] list_count;

    cam_stream_packer_if #(.DW(IDW)) s_if ();
    cam_stream_packer_if #(.DW(DW))  m_if ();

    cam_stream_packer #(.C_DATA_WIDTH(DW), .C_ID_WIDTH(IDW)) dut (
        .ap_clk     (ap_clk),
        .ap_rst_n   (ap_rst_n),
        .s          (s_if),
        .m          (m_if),
        .list_count (list_count)
    );

    always #5 ap_clk = ~ap_clk;

    int             checks     = 0;
    int             errors     = 0;
    int             lists_sent = 0;
    int             rdy_mode   = 0;   // 0 always ready, 1 random, 2 stalled
    bit             gaps       = 1'b0;
    logic [DW-1:0]  exp_q [$];
    logic [DW-1:0]  last_exp;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    // Downstream ready generator.
    initial begin
        m_if.TREADY = 1'b0;
        forever begin
            @(posedge ap_clk);
            #2;
            case (rdy_mode)
                0:       m_if.TREADY = 1'b1;
                1:       m_if.TREADY = 1'($urandom_range(0, 1));
                default: m_if.TREADY = 1'b0;
            endcase
        end
    end

    // Monitor: each handshake seen at the negedge happens at the next posedge.
    initial begin
        logic [DW-1:0] e;
        forever begin
            @(negedge ap_clk);
            if (ap_rst_n && m_if.TVALID && m_if.TREADY) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got %0h expected none", m_if.TDATA);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat", m_if.TDATA, e);
                end
            end
        end
    end

    // Present one word and hold it until it is accepted. Idle cycles carry garbage.
    task automatic drive_word(input logic [31:0] data, input bit last, input bit user);
        bit ok;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) tick();
        end
        s_if.TVALID = 1'b1;
        s_if.TDATA  = data;
        s_if.TLAST  = last;
        s_if.TUSER  = user;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge ap_clk);
            if (s_if.TREADY) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        tick();
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no s_TREADY expected accept within 200 cycles");
        end
        s_if.TVALID = 1'b0;
        s_if.TDATA  = $urandom;
        s_if.TLAST  = 1'($urandom_range(0, 1));
        s_if.TUSER  = 1'($urandom_range(0, 1));
    endtask

    // Model: split the list into 16-word beats and queue the expected beats, then drive the words.
    task automatic send_list(input int n, input bit mode, input bit seq, input logic [31:0] base);
        logic [31:0]   words [$];
        logic [DW-1:0] e;
        int            cnt;
        for (int j = 0; j < n; j++) begin
            if (seq) words.push_back(base + 32'(j));
            else     words.push_back($urandom);
        end
        for (int b = 0; b * 16 < n; b++) begin
            e   = '0;
            cnt = (n - 16 * b > 16) ? 16 : n - 16 * b;
            for (int j = 0; j < cnt; j++) e[32*j +: 32] = words[16*b + j];
            e[516:512] = 5'(cnt);
            e[517]     = (16 * b + cnt == n);
            e[518]     = mode;
            e[519]     = (b == 0);
            exp_q.push_back(e);
            last_exp = e;
        end
        for (int j = 0; j < n; j++) begin
            drive_word(words[j], j == n - 1, (j == 0) ? mode : 1'($urandom_range(0, 1)));
        end
        lists_sent++;
    endtask

    task automatic drain();
        rdy_mode = 0;
        for (int i = 0; i < 500 && exp_q.size() != 0; i++) tick();
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d beats pending expected 0", exp_q.size());
        end
        repeat (2) tick();
    endtask

    initial begin
        s_if.TVALID = 1'b0;
        s_if.TDATA  = '0;
        s_if.TLAST  = 1'b0;
        s_if.TUSER  = 1'b0;

        // Reset state, with no clock edge needed.
        #1 ap_rst_n = 1'b0;
        #2;
        chk("rst_m_tvalid", DW'(m_if.TVALID), '0);
        chk("rst_s_tready", DW'(s_if.TREADY), '0);
        chk("rst_m_tdata", m_if.TDATA, '0);
        chk("rst_list_count", DW'(list_count), '0);
        repeat (3) @(posedge ap_clk);
        #1 ap_rst_n = 1'b1;
        @(negedge ap_clk);
        chk("post_rst_s_tready", DW'(s_if.TREADY), DW'(1));
        tick();

        // 16 IDs 1..16 in load mode give one full beat.
        send_list(16, 1'b0, 1'b1, 32'd1);
        drain();
        chk("list_count_16", DW'(list_count), DW'(lists_sent));

        // 17 IDs in query mode give a full beat and then a single-lane beat.
        send_list(17, 1'b1, 1'b1, 32'd1);
        drain();
        chk("list_count_17", DW'(list_count), DW'(lists_sent));

        // A single-word list is presented one cycle after acceptance.
        repeat (3) tick();
        chk("idle_m_tvalid", DW'(m_if.TVALID), '0);
        send_list(1, 1'b0, 1'b1, 32'h0000_ABCD);
        chk("latency_m_tvalid", DW'(m_if.TVALID), DW'(1));
        drain();

        // Backpressure: the beat is held and upstream is stalled for 10 cycles.
        rdy_mode = 2;
        repeat (2) tick();
        send_list(4, 1'b1, 1'b0, 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge ap_clk);
            chk("stall_s_tready", DW'(s_if.TREADY), '0);
            chk("stall_m_tvalid", DW'(m_if.TVALID), DW'(1));
            chk("stall_m_tdata", m_if.TDATA, last_exp);
        end
        tick();
        rdy_mode = 0;
        @(negedge ap_clk);
        chk("release_s_tready", DW'(s_if.TREADY), DW'(1));
        tick();
        drain();

        // Reset after 5 words of a list, then a fresh 3-word list.
        for (int j = 0; j < 5; j++) drive_word(32'(100 + j), 1'b0, 1'b1);
        @(posedge ap_clk);
        #3 ap_rst_n = 1'b0;
        #1;
        chk("mid_rst_m_tvalid", DW'(m_if.TVALID), '0);
        chk("mid_rst_s_tready", DW'(s_if.TREADY), '0);
        chk("mid_rst_m_tdata", m_if.TDATA, '0);
        chk("mid_rst_list_count", DW'(list_count), '0);
        exp_q.delete();
        lists_sent = 0;
        @(posedge ap_clk);
        #1 ap_rst_n = 1'b1;
        @(negedge ap_clk);
        chk("mid_post_rst_s_tready", DW'(s_if.TREADY), DW'(1));
        tick();
        send_list(3, 1'b0, 1'b0, 32'd0);
        drain();
        chk("list_count_after_rst", DW'(list_count), DW'(1));

        // Random lists, gaps and downstream ready.
        gaps = 1'b1;
        rdy_mode = 1;
        for (int l = 0; l < 40; l++) begin
            rdy_mode = 1;
            send_list($urandom_range(1, 40), 1'($urandom_range(0, 1)), 1'b0, 32'd0);
        end
        drain();
        chk("list_count_random", DW'(list_count), DW'(lists_sent));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cam_stream_packer.md
CAM_STREAM_PACKER -- requirements
Module: cam_stream_packer

Interface
REQ-001 SHALL have parameter C_DATA_WIDTH, default 520, output beat width; legal value only 16*C_ID_WIDTH+8.
REQ-002 SHALL have parameter C_ID_WIDTH, default 32, vertex-ID width.
REQ-003 SHALL have port ap_clk  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have port ap_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port s_TDATA  input  C_ID_WIDTH  one vertex ID per transfer.
REQ-006 SHALL have port s_TVALID  input  1  input word valid.
REQ-007 SHALL have port s_TREADY  output  1  input word accepted when high with s_TVALID.
REQ-008 SHALL have port s_TLAST  input  1  final word of an adjacency list.
REQ-009 SHALL have port s_TUSER  input  1  list mode, 0 = CAM load, 1 = CAM query.
REQ-010 SHALL have port m_TDATA  output  C_DATA_WIDTH  packed beat to CAM kernel input stream.
REQ-011 SHALL have port m_TVALID  output  1  beat valid.
REQ-012 SHALL have port m_TREADY  input  1  beat consumed when high with m_TVALID.
REQ-013 SHALL have port list_count  output  32  number of lists fully emitted.

Function
REQ-014 SHALL pack up to 16 accepted IDs into lanes m_TDATA[32k+31:32k], k = 0..15, lane k = k-th word of the beat in arrival order.
REQ-015 SHALL drive header m_TDATA[516:512] = valid lane count 1..16, [517] = last beat of list, [518] = list mode, [519] = first beat of list.
REQ-016 SHALL zero all unfilled lanes of every emitted beat.
REQ-017 SHALL drive s_TREADY = !m_TVALID || m_TREADY, combinational; no other stall source.
REQ-018 SHALL complete a beat on the accepted word with lane counter = 15 or s_TLAST = 1.
REQ-019 SHALL load the completed beat into the output register on the completing transfer's clock edge; m_TVALID high in the next cycle (1-cycle latency).
REQ-020 SHALL hold m_TDATA and m_TVALID stable while m_TVALID = 1 and m_TREADY = 0.
REQ-021 SHALL clear m_TVALID after a handshake unless a new beat is loaded in the same cycle; back-to-back beats sustain one beat per cycle.
REQ-022 SHALL sample s_TUSER on the first word of each list and apply it to all beats of that list; s_TUSER on later words ignored.
REQ-023 SHALL track an in-list flag: set by any accepted word with s_TLAST = 0, cleared by accepted word with s_TLAST = 1; first-beat bit = in-list flag clear at the beat's first word.
REQ-024 SHALL reset the lane counter to 0 on beat completion, otherwise increment per accepted word; counter 4 bits, no wrap beyond 15.
REQ-025 SHALL increment list_count by 1 on the m_TVALID/m_TREADY handshake of a beat with bit 517 = 1; wraps modulo 2^32.
REQ-026 SHALL ignore s_TDATA/s_TLAST/s_TUSER when s_TVALID = 0 or s_TREADY = 0.
REQ-027 SHALL never emit an empty beat; lists of zero words do not exist on the interface.

Reset
REQ-028 SHALL, with ap_rst_n low, immediately force m_TVALID = 0, s_TREADY = 0, m_TDATA = 0, list_count = 0, lane counter = 0, in-list flag = 0, mode = 0.
REQ-029 SHALL discard any partially packed beat and any undelivered output beat on reset mid-list.
REQ-030 SHALL drive s_TREADY = 1 in the first cycle after ap_rst_n deasserts.

Verification
REQ-031 SHALL pass: list of 16 IDs 1..16, s_TUSER = 0, m_TREADY = 1 -> one beat, lanes 1..16, count 16, first = 1, last = 1, mode = 0, list_count = 1.
REQ-032 SHALL pass: list of 17 IDs, s_TUSER = 1 -> beat A count 16, first = 1, last = 0, mode = 1; beat B count 1, lane0 = 17th ID, lanes 1..15 = 0, first = 0, last = 1, mode = 1.
REQ-033 SHALL pass: single-word list ID 0xABCD with s_TLAST = 1 -> beat count 1, first = last = 1, m_TVALID one cycle after acceptance.
REQ-034 SHALL pass: m_TREADY held low 10 cycles while beat pending -> s_TREADY = 0, m_TDATA unchanged all 10 cycles; release -> handshake, s_TREADY = 1 same cycle.
REQ-035 SHALL pass: ap_rst_n asserted after 5 words of a list -> all outputs 0 asynchronously; new 3-word list after release -> beat count 3, first = 1, no stale lanes.
REQ-036 SHALL pass: continuous random-length lists with random m_TREADY -> scoreboard lane/header match, no loss or duplication, list_count = lists sent.
